// File: rtl/fir_inverse8.sv
`default_nettype none
// ============================================================================
// fir_inverse8 : recovers x[n] from y[n] = sum b[k]*x[n-k] (b[0] = 1, mod 2^W)
//                using one time-multiplexed multiply-subtract per tap.
// Revision     : 1.0
// ============================================================================
module fir_inverse8 #(
  parameter int W    = 8,
  parameter int TAPS = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         coef_we,
  input  logic [2:0]   coef_addr,
  input  logic [W-1:0] coef_data,
  input  logic         hist_clr,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic         busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MAC  = 2'd1,
    S_OUT  = 2'd2
  } state_t;

  // Odd taps reset to 2, even taps to 1.
  function automatic logic [TAPS-1:1][W-1:0] f_coef_rst();
    logic [TAPS-1:1][W-1:0] v;
    for (int i = 1; i < TAPS; i++) begin
      v[i] = (i % 2 == 1) ? W'(2) : W'(1);
    end
    return v;
  endfunction

  localparam logic [TAPS-1:1][W-1:0] c_COEF_RST = f_coef_rst();

  state_t                  r_state;
  logic [W-1:0]            r_acc;
  logic [2:0]              r_k;
  logic [TAPS-1:1][W-1:0]  r_coef;
  logic [TAPS-2:0][W-1:0]  r_hist;   // r_hist[0] is x[n-1]

  logic [2:0]              w_hidx;
  logic [W-1:0]            w_prod;
  logic [W-1:0]            w_diff;

  assign w_hidx = r_k - 3'd1;
  assign w_prod = r_coef[r_k] * r_hist[w_hidx];
  assign w_diff = r_acc - w_prod;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_acc     <= '0;
      r_k       <= '0;
      r_coef    <= c_COEF_RST;
      r_hist    <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      busy      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (coef_we && (coef_addr != 3'd0)) begin
            r_coef[coef_addr] <= coef_data;
          end
          if (hist_clr) begin
            r_hist <= '0;
          end
          // The MAC reads coefficients and history only from the next cycle,
          // so same-cycle writes and clears are naturally seen by this sample.
          if (in_valid && in_ready) begin
            r_acc    <= in_data;
            r_k      <= 3'd1;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            r_state  <= S_MAC;
          end else begin
            in_ready <= 1'b1;
          end
        end
        S_MAC: begin
          r_acc <= w_diff;
          r_k   <= r_k + 3'd1;
          if (r_k == 3'(TAPS - 1)) begin
            out_valid <= 1'b1;
            out_data  <= w_diff;
            r_state   <= S_OUT;
          end
        end
        S_OUT: begin
          if (out_ready) begin
            r_hist    <= {r_hist[TAPS-3:0], r_acc};
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
            r_state   <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fir_inverse8.sv
`default_nettype none
// Testbench for fir_inverse8: directed scenarios plus randomized traffic
// compared against a plain-arithmetic model of the inverse filter.
module tb_fir_inverse8;

  logic       clk;
  logic       rst_n;
  logic       coef_we;
  logic [2:0] coef_addr;
  logic [7:0] coef_data;
  logic       hist_clr;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       busy;

  int n_total = 0;
  int n_bad   = 0;
  int cyc     = 0;
  int last_acc;

  fir_inverse8 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .coef_we   (coef_we),
    .coef_addr (coef_addr),
    .coef_data (coef_data),
    .hist_clr  (hist_clr),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Reference model: coefficients b[1..7] and past outputs x[n-1..n-7].
  logic [7:0] mb [1:7];
  logic [7:0] mh [1:7];

  task automatic m_reset();
    for (int k = 1; k <= 7; k++) begin
      mb[k] = (k % 2 == 1) ? 8'd2 : 8'd1;
      mh[k] = 8'd0;
    end
  endtask

  function automatic logic [7:0] m_x(input logic [7:0] y);
    logic [7:0] a;
    a = y;
    for (int k = 1; k <= 7; k++) a = a - 8'(mb[k] * mh[k]);
    return a;
  endfunction

  task automatic m_push(input logic [7:0] x);
    for (int k = 7; k >= 2; k--) mh[k] = mh[k-1];
    mh[1] = x;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0d expected=%0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    m_reset();
    step();
  endtask

  task automatic wr(input logic [2:0] a, input logic [7:0] d);
    coef_we   = 1'b1;
    coef_addr = a;
    coef_data = d;
    step();
    coef_we = 1'b0;
    if (a != 3'd0) mb[a] = d;
  endtask

  task automatic clr_hist();
    hist_clr = 1'b1;
    step();
    hist_clr = 1'b0;
    for (int k = 1; k <= 7; k++) mh[k] = 8'd0;
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (!in_ready && n < 50) begin
      step();
      n++;
    end
    if (!in_ready) chk("ready_timeout", 0, 1);
  endtask

  // One full transaction: accept, MAC latency, optional stall, handshake.
  task automatic xfer(input logic [7:0] y, input bit clr, input int stall,
                      input bit we, input logic [2:0] wa, input logic [7:0] wd,
                      input bit midwr, output logic [7:0] got);
    logic [7:0] exp;
    int n;
    wait_ready();
    out_ready = (stall == 0);
    in_valid  = 1'b1;
    in_data   = y;
    hist_clr  = clr;
    coef_we   = we;
    coef_addr = wa;
    coef_data = wd;
    step();
    last_acc = cyc;
    in_valid = 1'b0;
    hist_clr = 1'b0;
    coef_we  = 1'b0;
    in_data  = 8'($urandom);
    if (we && wa != 3'd0) mb[wa] = wd;
    if (clr) for (int k = 1; k <= 7; k++) mh[k] = 8'd0;
    exp = m_x(y);
    chk("in_ready_low_after_accept", in_ready, 0);
    chk("busy_after_accept", busy, 1);
    n = 0;
    while (!out_valid && n < 20) begin
      coef_we   = midwr && (n == 1);
      coef_addr = 3'd3;
      coef_data = 8'h55;
      step();
      n++;
    end
    coef_we = 1'b0;
    chk("latency", n, 7);
    chk("out_data", out_data, exp);
    got = out_data;
    for (int s = 0; s < stall; s++) begin
      in_valid = (s == 0);
      in_data  = 8'($urandom);
      step();
      in_valid = 1'b0;
      chk("stall_out_valid", out_valid, 1);
      chk("stall_out_data", out_data, exp);
      chk("stall_in_ready", in_ready, 0);
      chk("stall_busy", busy, 1);
    end
    out_ready = 1'b1;
    step();
    chk("hs_out_valid", out_valid, 0);
    chk("hs_in_ready", in_ready, 1);
    chk("hs_busy", busy, 0);
    m_push(exp);
  endtask

  task automatic send(input logic [7:0] y, output logic [7:0] got);
    xfer(y, 1'b0, 0, 1'b0, 3'd0, 8'd0, 1'b0, got);
  endtask

  logic [7:0] rt_y [8] = '{8'd1, 8'd2, 8'd2, 8'd4, 8'd3, 8'd6, 8'd4, 8'd9};
  logic [7:0] rt_x [8] = '{8'd1, 8'd0, 8'd1, 8'd0, 8'd1, 8'd0, 8'd1, 8'd1};

  initial begin
    #1000000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] got;
    logic [7:0] y;
    int prev_acc;
    rst_n = 1'b0; coef_we = 1'b0; coef_addr = '0; coef_data = '0;
    hist_clr = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    m_reset();
    step();
    step();
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_busy", busy, 0);
    rst_n = 1'b1;
    #1;
    chk("in_ready_before_first_edge", in_ready, 0);
    step();
    chk("in_ready_first_edge", in_ready, 1);

    // Default-coefficient round trip at full throughput.
    prev_acc = 0;
    for (int i = 0; i < 8; i++) begin
      send(rt_y[i], got);
      chk("roundtrip_value", got, rt_x[i]);
      if (i > 0) chk("accept_spacing", last_acc - prev_acc, 9);
      prev_acc = last_acc;
    end

    // Modulo wrap.
    do_reset();
    send(8'd5, got);
    chk("wrap_first", got, 5);
    send(8'd0, got);
    chk("wrap_second", got, 246);
    clr_hist();
    send(8'd255, got);
    chk("wrap_after_clr", got, 255);

    // Backpressure with an ignored in_valid pulse.
    xfer(8'd77, 1'b0, 3, 1'b0, 3'd0, 8'd0, 1'b0, got);
    send(8'd12, got);

    // Coefficient load: all-zero taps make the block transparent.
    do_reset();
    for (int k = 1; k <= 7; k++) wr(3'(k), 8'd0);
    wr(3'd0, 8'h77);
    for (int i = 0; i < 4; i++) begin
      y = 8'($urandom);
      xfer(y, 1'b0, 0, 1'b0, 3'd0, 8'd0, (i == 1), got);
      chk("zero_coef_passthru", got, y);
    end

    // Reset in the middle of the MAC sequence.
    do_reset();
    wait_ready();
    in_valid = 1'b1;
    in_data  = 8'd7;
    step();
    in_valid = 1'b0;
    step();
    step();
    step();
    @(posedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_in_ready", in_ready, 0);
    chk("midrst_out_data", out_data, 0);
    step();
    rst_n = 1'b1;
    m_reset();
    step();
    chk("midrst_no_output", out_valid, 0);
    send(8'd1, got);
    chk("midrst_after_1", got, 1);
    send(8'd2, got);
    chk("midrst_after_2", got, 0);

    // hist_clr coincident with accept.
    do_reset();
    send(8'd3, got);
    xfer(8'd4, 1'b1, 0, 1'b0, 3'd0, 8'd0, 1'b0, got);
    chk("clr_coincident", got, 4);

    // Coefficient write coincident with accept.
    xfer(8'd50, 1'b0, 0, 1'b1, 3'd1, 8'd9, 1'b0, got);

    // Randomized traffic.
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 3) == 0) wr(3'($urandom_range(0, 7)), 8'($urandom));
      if ($urandom_range(0, 9) == 0) clr_hist();
      xfer(8'($urandom), ($urandom_range(0, 7) == 0), $urandom_range(0, 2),
           ($urandom_range(0, 4) == 0), 3'($urandom_range(0, 7)), 8'($urandom),
           ($urandom_range(0, 3) == 0), got);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
